coin_pulse_queue: RTL

- Input-conditioning stage between the per-game joystick/button mapping and the in0/in1 coin bits fed to the pacman core.
- Debounces a raw coin request and queues up to QUEUE_MAX presses.
- Replays each queued press as a fixed-length, tick-timed coin pulse followed by a mandatory gap, so the Z80 coin routine never misses or merges credits.
- Pause-aware: timing freezes while the CPU is paused.

---
 rtl/coin_pulse_queue.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/coin_pulse_queue.sv
// Coin request conditioner: synchronises and debounces a raw coin input, queues presses,
// and replays each as a tick-timed pulse followed by a gap. Timing freezes while paused.
module coin_pulse_queue #(
    parameter int DEBOUNCE  = 4,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 4,
    parameter int QUEUE_MAX = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       pause,
    input  logic       coin_raw,
    output logic       coin_out,
    output logic [3:0] pending,
    output logic       busy,
    output logic       overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [7:0] DB_N  = 8'(DEBOUNCE);
    localparam logic [7:0] PL_N  = 8'(PULSE_LEN);
    localparam logic [7:0] GP_N  = 8'(GAP_LEN);
    localparam logic [3:0] Q_MAX = 4'(QUEUE_MAX);

    logic       s1_q, s2_q;
    logic       db_q, db_d;
    logic       db_dly_q;
    logic [7:0] dcnt_q, dcnt_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] state_q, state_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       coin_q, coin_d;
    logic       busy_q, busy_d;
    logic       ovf_q, ovf_d;

    logic rise, launch, qtick;

    always_comb begin
        rise   = db_q & ~db_dly_q;
        launch = (state_q == S_IDLE) && (pending_q != 4'd0) && !pause;
        qtick  = tick & ~pause;

        db_d      = db_q;
        dcnt_d    = dcnt_q;
        pending_d = pending_q;
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        coin_d    = coin_q;
        ovf_d     = 1'b0;

        if (s2_q == db_q) begin
            dcnt_d = 8'd0;
        end else if (dcnt_q + 8'd1 == DB_N) begin
            db_d   = s2_q;
            dcnt_d = 8'd0;
        end else begin
            dcnt_d = dcnt_q + 8'd1;
        end

        // A press that coincides with a launch simply replaces the launched credit.
        case ({rise, launch})
            2'b10: begin
                if (pending_q < Q_MAX) pending_d = pending_q + 4'd1;
                else                   ovf_d     = 1'b1;
            end
            2'b01:   pending_d = pending_q - 4'd1;
            default: pending_d = pending_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d = S_PULSE;
                    coin_d  = 1'b1;
                    tcnt_d  = 8'd0;
                end
            end
            S_PULSE: begin
                if (qtick) begin
                    if (tcnt_q + 8'd1 == PL_N) begin
                        state_d = S_GAP;
                        coin_d  = 1'b0;
                        tcnt_d  = 8'd0;
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
            end
            S_GAP: begin
                if (qtick) begin
                    if (tcnt_q + 8'd1 == GP_N) begin
                        state_d = S_IDLE;
                        tcnt_d  = 8'd0;
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                coin_d  = 1'b0;
                tcnt_d  = 8'd0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            db_q      <= 1'b0;
            db_dly_q  <= 1'b0;
            dcnt_q    <= 8'd0;
            pending_q <= 4'd0;
            state_q   <= S_IDLE;
            tcnt_q    <= 8'd0;
            coin_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            s1_q      <= coin_raw;
            s2_q      <= s1_q;
            db_q      <= db_d;
            db_dly_q  <= db_q;
            dcnt_q    <= dcnt_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            coin_q    <= coin_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign coin_out = coin_q;
    assign pending  = pending_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule
